// File: rtl/decode_alu_stage.sv
// Decode stage for OP-IMM / OP instructions: produces ALU code, operand-B select and
// extended immediate, delivered through a 2-entry in-order buffer with a ready/valid handshake.

`ifndef ALU_NOP
`define ALU_NOP   5'd0
`define ALU_ADD   5'd1
`define ALU_SUB   5'd2
`define ALU_SLL   5'd3
`define ALU_SLT   5'd4
`define ALU_SLTU  5'd5
`define ALU_XOR   5'd6
`define ALU_SRL   5'd7
`define ALU_SRA   5'd8
`define ALU_OR    5'd9
`define ALU_AND   5'd10
`define ALU_ADDI  5'd11
`define ALU_SLTI  5'd12
`define ALU_SLTIU 5'd13
`define ALU_XORI  5'd14
`define ALU_ORI   5'd15
`define ALU_ANDI  5'd16
`define ALU_SLLI  5'd17
`define ALU_SRLI  5'd18
`define ALU_SRAI  5'd19
`endif

module decode_alu_stage #(
    parameter int XLEN     = 32,
    parameter int EN_RTYPE = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [XLEN-1:0]  imm_ext,
    output logic [4:0]       alu_control,
    output logic             use_imm,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu;
        logic            use_imm;
        logic            illegal;
    } entry_t;

    entry_t           w_dec;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic             w_shamt_ok;
    logic [5:0]       w_shamt;

    entry_t           r_buf0;
    entry_t           r_buf1;
    logic [1:0]       r_count;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_ill_cnt;

    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    // NOTE: every field gets a default before the case tree, so no path leaves a latch.
    always_comb begin
        w_funct3       = instr[14:12];
        w_funct7       = instr[31:25];
        w_dec          = '0;
        w_dec.rd       = instr[11:7];
        w_dec.rs1      = instr[19:15];
        w_dec.rs2      = instr[24:20];
        w_dec.alu      = `ALU_NOP;
        w_dec.illegal  = 1'b1;
        // RV64 shifts borrow instr[25] as shamt[5]; only the bits above it must match.
        if (XLEN == 64) begin
            w_shamt_ok = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);
            w_shamt    = instr[25:20];
        end else begin
            w_shamt_ok = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
            w_shamt    = {1'b0, instr[24:20]};
        end

        if (instr[6:0] == OPC_OP_IMM) begin
            case (w_funct3)
                3'b001: begin
                    if (w_shamt_ok && !instr[30]) begin
                        w_dec.alu     = `ALU_SLLI;
                        w_dec.imm     = XLEN'(w_shamt);
                        w_dec.use_imm = 1'b1;
                        w_dec.illegal = 1'b0;
                    end
                end
                3'b101: begin
                    if (w_shamt_ok) begin
                        w_dec.alu     = instr[30] ? `ALU_SRAI : `ALU_SRLI;
                        w_dec.imm     = XLEN'(w_shamt);
                        w_dec.use_imm = 1'b1;
                        w_dec.illegal = 1'b0;
                    end
                end
                default: begin
                    case (w_funct3)
                        3'b000:  w_dec.alu = `ALU_ADDI;
                        3'b010:  w_dec.alu = `ALU_SLTI;
                        3'b011:  w_dec.alu = `ALU_SLTIU;
                        3'b100:  w_dec.alu = `ALU_XORI;
                        3'b110:  w_dec.alu = `ALU_ORI;
                        default: w_dec.alu = `ALU_ANDI;
                    endcase
                    w_dec.imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
                    w_dec.use_imm = 1'b1;
                    w_dec.illegal = 1'b0;
                end
            endcase
        end else if ((instr[6:0] == OPC_OP) && (EN_RTYPE != 0)) begin
            if (w_funct7 == 7'b0000000) begin
                w_dec.illegal = 1'b0;
                case (w_funct3)
                    3'b000:  w_dec.alu = `ALU_ADD;
                    3'b001:  w_dec.alu = `ALU_SLL;
                    3'b010:  w_dec.alu = `ALU_SLT;
                    3'b011:  w_dec.alu = `ALU_SLTU;
                    3'b100:  w_dec.alu = `ALU_XOR;
                    3'b101:  w_dec.alu = `ALU_SRL;
                    3'b110:  w_dec.alu = `ALU_OR;
                    default: w_dec.alu = `ALU_AND;
                endcase
            end else if (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
                w_dec.illegal = 1'b0;
                w_dec.alu     = (w_funct3 == 3'b000) ? `ALU_SUB : `ALU_SRA;
            end
        end
    end

    assign w_out_valid = (r_count != 2'd0);
    assign w_pop       = w_out_valid & out_ready;
    assign w_push      = in_valid & r_in_ready & ~flush;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = 2'd0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // NOTE: the buffer entries are reset too, so no stale decode can ever reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b0;
            r_ill_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
            if (w_pop && r_buf0.illegal && (r_ill_cnt != '1)) begin
                r_ill_cnt <= r_ill_cnt + CNT_W'(1);
            end
            if (!flush) begin
                if (w_pop) begin
                    r_buf0 <= (w_push && r_count == 2'd1) ? w_dec : r_buf1;
                    if (w_push) begin
                        r_buf1 <= w_dec;
                    end
                end else if (w_push) begin
                    if (r_count == 2'd0) begin
                        r_buf0 <= w_dec;
                    end else begin
                        r_buf1 <= w_dec;
                    end
                end
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = w_out_valid;
    assign rd          = w_out_valid ? r_buf0.rd      : 5'd0;
    assign rs1         = w_out_valid ? r_buf0.rs1     : 5'd0;
    assign rs2         = w_out_valid ? r_buf0.rs2     : 5'd0;
    assign imm_ext     = w_out_valid ? r_buf0.imm     : '0;
    assign alu_control = w_out_valid ? r_buf0.alu     : `ALU_NOP;
    assign use_imm     = w_out_valid & r_buf0.use_imm;
    assign illegal     = w_out_valid & r_buf0.illegal;
    assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_decode_alu_stage.sv
// Bench for decode_alu_stage: three configurations share one stimulus stream and are
// checked every cycle against a rule-level decode model and a queue of accepted words.

`ifndef ALU_NOP
`define ALU_NOP   5'd0
`define ALU_ADD   5'd1
`define ALU_SUB   5'd2
`define ALU_SLL   5'd3
`define ALU_SLT   5'd4
`define ALU_SLTU  5'd5
`define ALU_XOR   5'd6
`define ALU_SRL   5'd7
`define ALU_SRA   5'd8
`define ALU_OR    5'd9
`define ALU_AND   5'd10
`define ALU_ADDI  5'd11
`define ALU_SLTI  5'd12
`define ALU_SLTIU 5'd13
`define ALU_XORI  5'd14
`define ALU_ORI   5'd15
`define ALU_ANDI  5'd16
`define ALU_SLLI  5'd17
`define ALU_SRLI  5'd18
`define ALU_SRAI  5'd19
`endif

module tb_decode_alu_stage;

    localparam logic [4:0] IMM_OPS [8] = '{`ALU_ADDI, `ALU_SLLI, `ALU_SLTI, `ALU_SLTIU,
                                           `ALU_XORI, `ALU_SRLI, `ALU_ORI, `ALU_ANDI};
    localparam logic [4:0] REG_OPS [8] = '{`ALU_ADD, `ALU_SLL, `ALU_SLT, `ALU_SLTU,
                                           `ALU_XOR, `ALU_SRL, `ALU_OR, `ALU_AND};

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic [4:0]  alu;
        logic        use_imm;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [31:0] instr;

    logic        ir32, ov32, ui32, ill32;
    logic [4:0]  rd32, rs1_32, rs2_32, alu32;
    logic [31:0] imm32;
    logic [7:0]  cnt32;

    logic        ir64, ov64, ui64, ill64;
    logic [4:0]  rd64, rs1_64, rs2_64, alu64;
    logic [63:0] imm64;
    logic [2:0]  cnt64;

    logic        irnr, ovnr, uinr, illnr;
    logic [4:0]  rdnr, rs1_nr, rs2_nr, alunr;
    logic [31:0] immnr;
    logic [7:0]  cntnr;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] q[$];
    int          exp_cnt [3] = '{0, 0, 0};
    int          cnt_max [3] = '{255, 7, 255};
    bit          rdy_ok = 1'b0;

    always #5 clk = ~clk;

    decode_alu_stage #(.XLEN(32), .EN_RTYPE(1), .CNT_W(8)) u_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .instr(instr),
        .flush(flush), .out_valid(ov32), .out_ready(out_ready), .rd(rd32), .rs1(rs1_32),
        .rs2(rs2_32), .imm_ext(imm32), .alu_control(alu32), .use_imm(ui32),
        .illegal(ill32), .illegal_cnt(cnt32));

    decode_alu_stage #(.XLEN(64), .EN_RTYPE(1), .CNT_W(3)) u_d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64), .instr(instr),
        .flush(flush), .out_valid(ov64), .out_ready(out_ready), .rd(rd64), .rs1(rs1_64),
        .rs2(rs2_64), .imm_ext(imm64), .alu_control(alu64), .use_imm(ui64),
        .illegal(ill64), .illegal_cnt(cnt64));

    decode_alu_stage #(.XLEN(32), .EN_RTYPE(0), .CNT_W(8)) u_dnr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irnr), .instr(instr),
        .flush(flush), .out_valid(ovnr), .out_ready(out_ready), .rd(rdnr), .rs1(rs1_nr),
        .rs2(rs2_nr), .imm_ext(immnr), .alu_control(alunr), .use_imm(uinr),
        .illegal(illnr), .illegal_cnt(cntnr));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Decode rules written straight from the instruction-set tables.
    function automatic exp_t model(input logic [31:0] w, input bit x64, input bit rtype);
        exp_t       m;
        int         top;
        int         shamt;
        logic [2:0] f3;
        m       = '0;
        m.alu   = `ALU_NOP;
        m.ill   = 1'b1;
        m.rd    = w[11:7];
        m.rs1   = w[19:15];
        m.rs2   = w[24:20];
        f3      = w[14:12];
        if (w[6:0] == 7'b0010011) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                top   = x64 ? int'(w[31:26]) : int'(w[31:25]);
                shamt = x64 ? int'(w[25:20]) : int'(w[24:20]);
                if (top == 0 || (f3 == 3'd5 && top == (x64 ? 16 : 32))) begin
                    m.alu     = (f3 == 3'd1) ? `ALU_SLLI : ((top == 0) ? `ALU_SRLI : `ALU_SRAI);
                    m.imm     = 64'(shamt);
                    m.use_imm = 1'b1;
                    m.ill     = 1'b0;
                end
            end else begin
                m.alu     = IMM_OPS[f3];
                m.imm     = 64'($signed(w[31:20]));
                if (!x64) m.imm = m.imm & 64'hFFFF_FFFF;
                m.use_imm = 1'b1;
                m.ill     = 1'b0;
            end
        end else if (w[6:0] == 7'b0110011 && rtype) begin
            if (w[31:25] == 7'd0) begin
                m.alu = REG_OPS[f3];
                m.ill = 1'b0;
            end else if (w[31:25] == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                m.alu = (f3 == 3'd0) ? `ALU_SUB : `ALU_SRA;
                m.ill = 1'b0;
            end
        end
        return m;
    endfunction

    task automatic check_one(input string tag, input int k, input logic ov, input logic ir,
                             input logic [4:0] rd_o, input logic [4:0] rs1_o, input logic [4:0] rs2_o,
                             input logic [63:0] imm_o, input logic [4:0] alu_o, input logic ui_o,
                             input logic ill_o, input logic [7:0] cnt_o);
        exp_t e;
        bit   vld;
        vld = (q.size() != 0);
        if (vld) begin
            e = model(q[0], k == 1, k != 2);
        end else begin
            e     = '0;
            e.alu = `ALU_NOP;
        end
        check({tag, ".out_valid"}, 64'(ov), 64'(vld));
        check({tag, ".in_ready"}, 64'(ir), 64'(rdy_ok && q.size() < 2));
        check({tag, ".rd"}, 64'(rd_o), 64'(e.rd));
        check({tag, ".rs1"}, 64'(rs1_o), 64'(e.rs1));
        check({tag, ".rs2"}, 64'(rs2_o), 64'(e.rs2));
        check({tag, ".imm_ext"}, imm_o, e.imm);
        check({tag, ".alu_control"}, 64'(alu_o), 64'(e.alu));
        check({tag, ".use_imm"}, 64'(ui_o), 64'(e.use_imm));
        check({tag, ".illegal"}, 64'(ill_o), 64'(e.ill));
        check({tag, ".illegal_cnt"}, 64'(cnt_o), 64'(exp_cnt[k]));
    endtask

    task automatic check_all();
        check_one("x32", 0, ov32, ir32, rd32, rs1_32, rs2_32, {32'h0, imm32}, alu32, ui32, ill32, cnt32);
        check_one("x64", 1, ov64, ir64, rd64, rs1_64, rs2_64, imm64, alu64, ui64, ill64, {5'h0, cnt64});
        check_one("nor", 2, ovnr, irnr, rdnr, rs1_nr, rs2_nr, {32'h0, immnr}, alunr, uinr, illnr, cntnr);
    endtask

    // One clock: drive, check at the falling edge, predict the rising edge, update the model.
    task automatic cycle(input bit v, input logic [31:0] w, input bit fl, input bit ordy);
        bit push;
        bit pop;
        in_valid  = v;
        instr     = w;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
        check_all();
        pop  = (q.size() != 0) && ordy;
        push = v && rdy_ok && (q.size() < 2) && !fl;
        @(posedge clk);
        if (pop) begin
            for (int k = 0; k < 3; k++) begin
                if (model(q[0], k == 1, k != 2).ill && exp_cnt[k] < cnt_max[k]) exp_cnt[k]++;
            end
            void'(q.pop_front());
        end
        if (fl) q.delete();
        else if (push) q.push_back(w);
        rdy_ok = 1'b1;
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_cnt = '{0, 0, 0};
        rdy_ok  = 1'b0;
        check("rst.out_valid", 64'(ov32), 64'd0);
        check("rst.illegal_cnt", 64'(cnt32), 64'd0);
        check("rst.in_ready", 64'(ir32), 64'd0);
        check_all();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rdy_ok = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          r;
        w = $urandom;
        r = $urandom_range(0, 9);
        if (r < 4) w[6:0] = 7'b0010011;
        else if (r < 8) w[6:0] = 7'b0110011;
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        instr     = 32'h0;
        #3;
        apply_reset();

        // Directed decodes.
        cycle(1, 32'hFFF10093, 0, 1);
        check("addi.rd", 64'(rd32), 64'd1);
        check("addi.rs1", 64'(rs1_32), 64'd2);
        check("addi.imm32", 64'(imm32), 64'hFFFF_FFFF);
        check("addi.imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi.alu", 64'(alu32), 64'(`ALU_ADDI));
        check("addi.use_imm", 64'(ui32), 64'd1);
        cycle(1, 32'h4030D093, 0, 1);
        check("srai.alu", 64'(alu32), 64'(`ALU_SRAI));
        check("srai.imm", 64'(imm32), 64'd3);
        cycle(1, 32'h02009093, 0, 1);
        check("slli32.illegal", 64'(ill32), 64'd1);
        check("slli32.alu", 64'(alu32), 64'(`ALU_NOP));
        check("slli32.cnt_before", 64'(cnt32), 64'd0);
        check("slli64.alu", 64'(alu64), 64'(`ALU_SLLI));
        check("slli64.imm", imm64, 64'd32);
        cycle(1, 32'h40208033, 0, 1);
        check("slli32.cnt_after", 64'(cnt32), 64'd1);
        check("sub.alu", 64'(alu32), 64'(`ALU_SUB));
        check("sub.rs2", 64'(rs2_32), 64'd2);
        check("sub.use_imm", 64'(ui32), 64'd0);
        check("sub_nor.illegal", 64'(illnr), 64'd1);
        cycle(0, 32'h0, 0, 1);

        // Backpressure: two accepted, third waits, drain in order.
        cycle(1, 32'h00500293, 0, 0);
        cycle(1, 32'h00600313, 0, 0);
        cycle(1, 32'h00700393, 0, 0);
        check("bp.in_ready_full", 64'(ir32), 64'd0);
        check("bp.head_a", 64'(rd32), 64'd5);
        cycle(1, 32'h00700393, 0, 1);
        check("bp.head_b", 64'(rd32), 64'd6);
        check("bp.in_ready_free", 64'(ir32), 64'd1);
        cycle(1, 32'h00700393, 0, 1);
        check("bp.head_c", 64'(rd32), 64'd7);
        cycle(0, 32'h0, 0, 1);
        check("bp.drained", 64'(ov32), 64'd0);

        // Flush with a full buffer and an instruction offered.
        cycle(1, 32'h00500293, 0, 0);
        cycle(1, 32'h00600313, 0, 0);
        cycle(1, 32'h00700393, 1, 0);
        check("flush.out_valid", 64'(ov32), 64'd0);
        check("flush.in_ready", 64'(ir32), 64'd1);
        cycle(0, 32'h0, 0, 1);
        cycle(0, 32'h0, 0, 1);

        // Reset asserted mid-stream with a non-zero illegal count.
        cycle(1, 32'h0000007F, 0, 0);
        cycle(1, 32'h00500293, 0, 0);
        #2;
        apply_reset();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0);
        end

        // Drive the narrow counter into saturation.
        for (int i = 0; i < 12; i++) cycle(1, 32'h0000007F, 0, 1);
        cycle(0, 32'h0, 0, 1);
        cycle(0, 32'h0, 0, 1);
        check("sat.cnt64", 64'(cnt64), 64'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
